mod_exp_ctrl: RTL and testbench

- Sequencer that computes result = X^E mod M by driving the radix-4 Montgomery product engine (mon_prod) through its start/stop interface.
- Acts as the initiator to the engine's responder role. It issues square and multiply products MSB-first across the exponent, then performs one final product by 1 to leave the Montgomery domain.
- Sits between the RSA top-level (supplies operands and pre-computed Montgomery constants) and mon_prod.

---
 rtl/mod_exp_pkg.sv | 37 +++
 rtl/mp_handshake.sv | 63 ++++++
 rtl/mod_exp_ctrl.sv | 178 +++++++++++++++++
 tb/tb_mod_exp_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mod_exp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mod_exp_pkg
// Description : Shared types and defaults for the modular-exponentiation
//               sequencer and its engine handshake. The defaults match the
//               Montgomery engine's BITLEN and BETA constants.
//               Contents: sequencer state encoding, op-tag encoding and the
//               default operand and exponent widths.
// Revision    : 1.0 - initial release
// ============================================================================
package mod_exp_pkg;

    localparam int c_default_width    = 1024;
    localparam int c_default_exp_bits = 1024;

    // The sequencer uses IDLE..WAIT..FIN. The handshake uses IDLE/ISSUE/ARM/WAIT.
    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_LOAD  = 4'd1,
        ST_SQ    = 4'd2,
        ST_MUL   = 4'd3,
        ST_EXIT  = 4'd4,
        ST_ISSUE = 4'd5,
        ST_ARM   = 4'd6,
        ST_WAIT  = 4'd7,
        ST_FIN   = 4'd8
    } state_t;

    // Kind of product in flight. It selects where the sequencer goes after the capture.
    typedef enum logic [1:0] {
        TAG_SQR = 2'd0,
        TAG_MUL = 2'd1,
        TAG_EXT = 2'd2
    } tag_t;

endpackage
`default_nettype wire

// File: rtl/mp_handshake.sv
`default_nettype none
// ============================================================================
// Module      : mp_handshake
// Description : Initiator side of the Montgomery engine start/stop protocol.
//               On req it waits for the engine to be idle (mp_done=1). It then
//               pulses mp_start for one cycle and waits for mp_done to drop.
//               After that it waits for mp_done to rise again and raises a
//               one-cycle capture strobe in that cycle.
// Ports       : clk, reset    - clock, synchronous active-high reset
//               req           - begin a product (ignored while one is open)
//               mp_done       - engine stop flag, high while idle/finished
//               mp_start      - registered one-cycle engine start pulse
//               capture       - product valid on mp_p this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module mp_handshake
    import mod_exp_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic mp_done,
    output logic mp_start,
    output logic capture
);

    state_t r_state;
    state_t w_next;
    logic   w_fire;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            mp_start <= 1'b0;
        end else begin
            r_state  <= w_next;
            mp_start <= w_fire;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_fire  = 1'b0;
        capture = 1'b0;
        case (r_state)
            ST_IDLE:  if (req) w_next = ST_ISSUE;
            // A previous job may still be running after a reset, so wait for idle.
            ST_ISSUE: if (mp_done) begin
                          w_fire = 1'b1;
                          w_next = ST_ARM;
                      end
            // mp_done is still high from idle, so wait until the engine drops it.
            ST_ARM:   if (!mp_done) w_next = ST_WAIT;
            ST_WAIT:  if (mp_done) begin
                          capture = 1'b1;
                          w_next  = ST_IDLE;
                      end
            default:  w_next = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mod_exp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mod_exp_ctrl
// Description : Computes result = X^E mod M with the Montgomery product engine.
//               It scans the exponent MSB-first. Each bit gets a square
//               product, and a 1-bit adds a multiply by x_bar. A final product
//               by 1 leaves the Montgomery domain.
// Config      : SKIP_LEADING_ZEROS_EN - consume leading zero exponent bits at
//               one bit per cycle without issuing square products.
// Ports       : clk, reset           - clock, synchronous active-high reset
//               start                - job request, operands sampled on accept
//               x_bar, one_bar, e, m - Montgomery base, R mod M, exponent, modulus
//               busy, done, result   - job status and X^E mod M
//               mp_start, mp_a, mp_b, mp_m, mp_done, mp_p - engine interface
// Revision    : 1.0 - initial release
// ============================================================================
module mod_exp_ctrl
    import mod_exp_pkg::*;
#(
    parameter int WIDTH    = c_default_width,
    parameter int EXP_BITS = c_default_exp_bits,
    parameter int CNT_W    = $clog2(EXP_BITS) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [WIDTH-1:0]    x_bar,
    input  logic [WIDTH-1:0]    one_bar,
    input  logic [EXP_BITS-1:0] e,
    input  logic [WIDTH-1:0]    m,
    output logic                busy,
    output logic                done,
    output logic [WIDTH-1:0]    result,
    output logic                mp_start,
    output logic [WIDTH-1:0]    mp_a,
    output logic [WIDTH-1:0]    mp_b,
    output logic [WIDTH-1:0]    mp_m,
    input  logic                mp_done,
    input  logic [WIDTH-1:0]    mp_p
);

    state_t              r_state;
    state_t              w_next;
    tag_t                r_tag;
    logic [WIDTH-1:0]    r_x_bar;
    logic [WIDTH-1:0]    r_p;
    logic [EXP_BITS-1:0] r_e;
    logic [CNT_W-1:0]    r_idx;
    logic                w_ebit;
    logic                w_idx_zero;
    logic                w_skip;
    logic                w_capture;
    logic                w_hs_req;

    assign w_ebit     = |(r_e & (EXP_BITS'(1) << r_idx));
    assign w_idx_zero = (r_idx == '0);
    assign w_hs_req   = (r_state == ST_ISSUE);

`ifdef SKIP_LEADING_ZEROS_EN
    // High until the first 1-bit is reached. Until then P is still one_bar,
    // so squaring it would not change anything.
    logic r_lead;

    always_ff @(posedge clk) begin
        if (reset)
            r_lead <= 1'b0;
        else if (r_state == ST_IDLE && start)
            r_lead <= 1'b1;
        else if (r_state == ST_SQ && !w_skip)
            r_lead <= 1'b0;
    end

    assign w_skip = r_lead & ~w_ebit;
`else
    assign w_skip = 1'b0;
`endif

    mp_handshake u_hs (
        .clk      (clk),
        .reset    (reset),
        .req      (w_hs_req),
        .mp_done  (mp_done),
        .mp_start (mp_start),
        .capture  (w_capture)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next = ST_LOAD;
            ST_LOAD:  w_next = ST_SQ;
            ST_SQ:    if (w_skip) w_next = w_idx_zero ? ST_EXIT : ST_SQ;
                      else        w_next = ST_ISSUE;
            ST_MUL:   w_next = ST_ISSUE;
            ST_EXIT:  w_next = ST_ISSUE;
            ST_ISSUE: w_next = ST_WAIT;
            ST_WAIT:  if (w_capture) begin
                          case (r_tag)
                              TAG_SQR: if (w_ebit)          w_next = ST_MUL;
                                       else if (w_idx_zero) w_next = ST_EXIT;
                                       else                 w_next = ST_SQ;
                              TAG_MUL: w_next = w_idx_zero ? ST_EXIT : ST_SQ;
                              default: w_next = ST_FIN;
                          endcase
                      end
            ST_FIN:   w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Engine operands change only in SQ/MUL/EXIT. They stay stable from the
    // start pulse until the capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            mp_a    <= '0;
            mp_b    <= '0;
            mp_m    <= '0;
            r_x_bar <= '0;
            r_p     <= '0;
            r_e     <= '0;
            r_idx   <= '0;
            r_tag   <= TAG_SQR;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: if (start) begin
                    r_x_bar <= x_bar;
                    r_p     <= one_bar;
                    r_e     <= e;
                    mp_m    <= m;
                    r_idx   <= CNT_W'(EXP_BITS - 1);
                    busy    <= 1'b1;
                end
                ST_SQ: begin
                    if (w_skip) begin
                        if (!w_idx_zero) r_idx <= r_idx - CNT_W'(1);
                    end else begin
                        mp_a  <= r_p;
                        mp_b  <= r_p;
                        r_tag <= TAG_SQR;
                    end
                end
                ST_MUL: begin
                    mp_a  <= r_p;
                    mp_b  <= r_x_bar;
                    r_tag <= TAG_MUL;
                end
                ST_EXIT: begin
                    mp_a  <= r_p;
                    mp_b  <= WIDTH'(1);
                    r_tag <= TAG_EXT;
                end
                ST_WAIT: if (w_capture) begin
                    r_p <= mp_p;
                    // Step to the next bit unless a multiply for this bit is still pending.
                    if (((r_tag == TAG_SQR && !w_ebit) || r_tag == TAG_MUL) && !w_idx_zero)
                        r_idx <= r_idx - CNT_W'(1);
                end
                ST_FIN: begin
                    result <= r_p;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mod_exp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_exp_ctrl
// Description : Self-checking bench for mod_exp_ctrl (WIDTH=16, EXP_BITS=4).
//               It includes a behavioural Montgomery engine with R=2^16 and
//               variable latency. Results are compared against plain modular
//               exponentiation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_exp_ctrl;

    localparam int W  = 16;
    localparam int EB = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  x_bar = '0;
    logic [W-1:0]  one_bar = '0;
    logic [W-1:0]  m = '0;
    logic [EB-1:0] e = '0;
    logic          busy, done, mp_start, mp_done;
    logic [W-1:0]  result, mp_a, mp_b, mp_m, mp_p;

    int checks = 0;
    int errors = 0;

    // behavioural engine state
    logic         eng_done = 1'b1;
    logic [W-1:0] eng_p = '0, ea = '0, eb = '0, em = '0;
    int           eng_cnt = 0;
    int           eng_starts = 0;
    int           stall_at = -1;
    logic         skip_stale = 1'b0;

    assign mp_done = eng_done;
    assign mp_p    = eng_p;

    always #5 clk = ~clk;

    mod_exp_ctrl #(.WIDTH(W), .EXP_BITS(EB)) dut (
        .clk(clk), .reset(reset), .start(start), .x_bar(x_bar), .one_bar(one_bar),
        .e(e), .m(m), .busy(busy), .done(done), .result(result),
        .mp_start(mp_start), .mp_a(mp_a), .mp_b(mp_b), .mp_m(mp_m),
        .mp_done(mp_done), .mp_p(mp_p)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // a*b*R^-1 mod mm with R = 2^16
    function automatic longint monpro(input longint a, input longint b, input longint mm);
        longint ri = 0;
        if (mm <= 1) return 0;
        for (longint r = 1; r < mm; r++)
            if (((65536 * r) % mm) == 1) begin ri = r; break; end
        return (((a % mm) * (b % mm)) % mm) * ri % mm;
    endfunction

    function automatic longint powmod(input longint x, input int ex, input longint mm);
        longint r = 1 % mm;
        for (int i = 0; i < ex; i++) r = (r * x) % mm;
        return r;
    endfunction

    function automatic int exp_pulses(input logic [EB-1:0] ee);
        int ones = 0;
        int msb = -1;
        for (int i = 0; i < EB; i++)
            if (ee[i]) begin ones++; msb = i; end
`ifdef SKIP_LEADING_ZEROS_EN
        return (msb + 1) + ones + 1;
`else
        return EB + ones + 1;
`endif
    endfunction

    // engine: latches operands on start, drops done, finishes after a latency
    always @(posedge clk) begin
        if (mp_start) begin
            ea         <= mp_a;
            eb         <= mp_b;
            em         <= mp_m;
            eng_done   <= 1'b0;
            eng_starts <= eng_starts + 1;
            eng_cnt    <= (eng_starts == stall_at) ? 200 : int'($urandom_range(1, 5));
        end else if (!eng_done) begin
            if (eng_cnt <= 1) begin
                eng_p    <= W'(monpro(longint'(ea), longint'(eb), longint'(em)));
                eng_done <= 1'b1;
            end else begin
                eng_cnt <= eng_cnt - 1;
            end
        end
    end

    // protocol monitor: no start onto a busy engine, operands stable while it runs
    always @(negedge clk) begin
        if (reset)         skip_stale <= 1'b1;
        else if (eng_done) skip_stale <= 1'b0;
        if (mp_start) check("start_engine_idle", eng_done, 1);
        if (!eng_done && !skip_stale && !reset) begin
            check("mp_a_stable", mp_a, ea);
            check("mp_b_stable", mp_b, eb);
            check("mp_m_stable", mp_m, em);
        end
    end

    task automatic run_job(input longint mm, input longint xx, input logic [EB-1:0] ee,
                           input bit poke);
        longint xb, ob, expv;
        int     s0;
        bit     got;
        xb   = (xx * 65536) % mm;
        ob   = 65536 % mm;
        expv = powmod(xx % mm, int'(ee), mm);
        @(negedge clk);
        s0      = eng_starts;
        start   = 1'b1;
        x_bar   = W'(xb);
        one_bar = W'(ob);
        e       = ee;
        m       = W'(mm);
        @(negedge clk);
        start   = 1'b0;
        x_bar   = W'($urandom);
        one_bar = W'($urandom);
        e       = EB'($urandom);
        m       = W'($urandom);
        got     = 1'b0;
        for (int cyc = 0; cyc < 5000 && !got; cyc++) begin
            if (done) begin
                got = 1'b1;
            end else begin
                check("busy_during_job", busy, 1);
                start = poke && (cyc == 20);
                @(negedge clk);
            end
        end
        start = 1'b0;
        check("job_completes", got, 1);
        if (got) begin
            check("result", result, expv);
            check("busy_at_done", busy, 0);
            check("mp_start_pulses", eng_starts - s0, exp_pulses(ee));
            check("mp_m_latched", mp_m, mm);
            @(negedge clk);
            check("done_one_cycle", done, 0);
            check("result_held", result, expv);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_mp_start", mp_start, 0);
        check("rst_mp_a", mp_a, 0);
        check("rst_mp_b", mp_b, 0);
        check("rst_mp_m", mp_m, 0);
        reset = 1'b0;

        run_job(13, 5, 4'd3, 1'b0);
        run_job(13, 5, 4'd0, 1'b0);
        run_job(13, 5, 4'd1, 1'b0);
        run_job(13, 5, 4'd15, 1'b0);
        run_job(1, 0, 4'd5, 1'b0);
        // second start mid-job must be ignored
        run_job(13, 5, 4'd15, 1'b1);
        // long engine stall on the third product of the next job
        stall_at = eng_starts + 2;
        run_job(13, 7, 4'd11, 1'b0);

        for (int i = 0; i < 8; i++) begin
            longint mm;
            mm = 2 * longint'($urandom_range(0, 32767)) + 1;
            run_job(mm, longint'($urandom) % mm, EB'($urandom), 1'b0);
        end

        // reset while the engine is stalled inside a product
        stall_at = eng_starts + 1;
        @(negedge clk);
        start = 1'b1; m = 16'd13; x_bar = W'((5 * 65536) % 13); one_bar = W'(65536 % 13); e = 4'd15;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2000 && !(eng_starts > stall_at && !eng_done); i++) @(negedge clk);
        check("stall_reached", (eng_starts > stall_at && !eng_done), 1);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_mp_start", mp_start, 0);
        check("mid_rst_mp_a", mp_a, 0);
        check("mid_rst_mp_b", mp_b, 0);
        check("mid_rst_mp_m", mp_m, 0);
        reset = 1'b0;
        // engine is still running the stale product; the new job must wait
        run_job(13, 6, 4'd7, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
